// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, controller states and small operation-decode helpers.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic is_signed_op(op_e op);
    return (op == MULT) || (op == DIV);
  endfunction

  function automatic logic is_div_op(op_e op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/md_signfix.sv
// Conditional two's-complement negate; doubles as absolute value when
// negate is driven from the operand's sign bit.
module md_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract
// step per cycle on operand magnitudes, with sign fix-up on completion.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done,
  output logic             busy,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  op_e              op_q, op_in;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] opnd_q, acc_hi_q, acc_lo_q;
  logic             quot_neg_q, rem_neg_q, div_zero_q;

  logic             accept, last_step, in_signed, in_div;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   add_a, add_b, sum;
  logic             sub;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix, res_hi, res_lo;

  assign op_in     = op_e'(op);
  assign in_signed = is_signed_op(op_in);
  assign in_div    = is_div_op(op_in);
  assign accept    = (state_q == IDLE) && start && !flush;
  assign last_step = (cnt_q == CW'(WIDTH - 1));

  md_signfix #(.WIDTH(WIDTH)) u_abs_a (
    .value(a), .negate(in_signed && a[WIDTH-1]), .result(abs_a)
  );

  md_signfix #(.WIDTH(WIDTH)) u_abs_b (
    .value(b), .negate(in_signed && b[WIDTH-1]), .result(abs_b)
  );

  // One shared adder: multiply adds the multiplicand into the upper half,
  // divide subtracts the divisor from the shifted partial remainder.
  always_comb begin
    sub   = is_div_op(op_q);
    add_a = {1'b0, acc_hi_q};
    add_b = '0;
    if (sub) begin
      add_a = {acc_hi_q, acc_lo_q[WIDTH-1]};
      add_b = {1'b0, opnd_q};
    end else if (acc_lo_q[0]) begin
      add_b = {1'b0, opnd_q};
    end
    sum = add_a + (add_b ^ {(WIDTH+1){sub}}) + {{WIDTH{1'b0}}, sub};
  end

  // Divide: sum[WIDTH] set means the trial subtraction borrowed, so restore.
  always_comb begin
    step_hi = sum[WIDTH:1];
    step_lo = {sum[0], acc_lo_q[WIDTH-1:1]};
    if (is_div_op(op_q)) begin
      if (sum[WIDTH]) begin
        step_hi = add_a[WIDTH-1:0];
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
      end else begin
        step_hi = sum[WIDTH-1:0];
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
      end
    end
  end

  md_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .value({step_hi, step_lo}), .negate(quot_neg_q), .result(prod_fix)
  );

  md_signfix #(.WIDTH(WIDTH)) u_fix_quot (
    .value(step_lo), .negate(quot_neg_q), .result(quot_fix)
  );

  md_signfix #(.WIDTH(WIDTH)) u_fix_rem (
    .value(step_hi), .negate(rem_neg_q), .result(rem_fix)
  );

  // A zero divisor leaves the dividend in the remainder, so only lo needs forcing.
  always_comb begin
    res_hi = rem_fix;
    res_lo = quot_fix;
    if (!is_div_op(op_q)) begin
      {res_hi, res_lo} = prod_fix;
    end else if (div_zero_q) begin
      res_lo = '1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (flush) state_d = IDLE;
               else if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE) && !flush;
  assign stall = rst_n && !flush && (accept || (state_q == CALC));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= MULT;
      cnt_q      <= '0;
      opnd_q     <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q       <= op_in;
            cnt_q      <= '0;
            acc_hi_q   <= '0;
            opnd_q     <= in_div ? abs_b : abs_a;
            acc_lo_q   <= in_div ? abs_a : abs_b;
            quot_neg_q <= in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            rem_neg_q  <= in_signed && a[WIDTH-1];
            div_zero_q <= in_div && (b == '0);
          end
        end
        CALC: begin
          if (!flush) begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
            cnt_q    <= cnt_q + 1'b1;
            if (last_step) begin
              hi <= res_hi;
              lo <= res_lo;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): directed corner cases plus
// random operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic [31:0] hi, lo;
  logic        done, busy, stall;

  int          vectors;
  int          miscompares;
  logic [31:0] expHi, expLo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi(hi), .lo(lo), .done(done), .busy(busy), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {hi, lo} computed with ordinary 64-bit arithmetic.
  function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = '0;
    case (o)
      MULT:  p = sx * sy;
      MULTU: p = {32'd0, x} * {32'd0, y};
      DIV: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else p = {x % y, x / y};
      end
    endcase
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Runs one operation from an IDLE cycle. pokeCycle pulses a junk start
  // mid-calculation; flushCycle aborts the operation in that cycle.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                               input int pokeCycle, input int flushCycle);
    logic [63:0] expected;
    int doneCycle, stallBad;
    bit flushed;
    expected  = refModel(o, x, y);
    doneCycle = -1;
    stallBad  = 0;
    flushed   = 1'b0;
    op = o; a = x; b = y; start = 1'b1;
    #1;
    checkOutput("stall_accept", {63'd0, stall}, 64'd1);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      a = $urandom; b = $urandom;
      if (c == pokeCycle) begin
        start = 1'b1;
        op    = 2'($urandom_range(0, 3));
      end
      if (c == flushCycle) flush = 1'b1;
      #1;
      if (c == flushCycle) begin
        flushed = 1'b1;
        break;
      end
      if (done) begin
        doneCycle = c;
        break;
      end
      if (!stall) stallBad++;
    end
    if (flushed) begin
      checkOutput("flush_done", {63'd0, done}, 64'd0);
      checkOutput("flush_stall", {63'd0, stall}, 64'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      #1;
      checkOutput("flush_busy", {63'd0, busy}, 64'd0);
      checkOutput("flush_hi", {32'd0, hi}, {32'd0, expHi});
      checkOutput("flush_lo", {32'd0, lo}, {32'd0, expLo});
    end else begin
      expHi = expected[63:32];
      expLo = expected[31:0];
      checkOutput("latency", 64'(doneCycle), 64'd33);
      checkOutput("stall_calc", 64'(stallBad), 64'd0);
      checkOutput("stall_done", {63'd0, stall}, 64'd0);
      checkOutput("hi", {32'd0, hi}, {32'd0, expHi});
      checkOutput("lo", {32'd0, lo}, {32'd0, expLo});
      start = 1'b1;
      op    = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      checkOutput("done_start_ignored", {63'd0, busy}, 64'd0);
    end
  endtask

  initial begin
    int doneSeen;
    logic [1:0]  rOp;
    logic [31:0] rA, rB;
    vectors = 0; miscompares = 0;
    expHi = '0; expLo = '0;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'd0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_hi", {32'd0, hi}, 64'd0);
    checkOutput("rst_lo", {32'd0, lo}, 64'd0);
    checkOutput("rst_flags", {61'd0, done, busy, stall}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed vectors");
    applyStimulus(MULT,  32'hFFFF_FFFE, 32'd3,        0, 0);
    applyStimulus(DIVU,  32'd100,       32'd7,        5, 0);
    applyStimulus(DIV,   32'hFFFF_FFF9, 32'd2,        0, 0);
    applyStimulus(DIVU,  32'd5,         32'd0,        0, 0);
    applyStimulus(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    applyStimulus(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    applyStimulus(DIVU,  32'd100,       32'd7,        0, 10);
    applyStimulus(MULTU, 32'd6,         32'd7,        0, 0);
    applyStimulus(DIV,   32'hFFFF_FFF0, 32'd0,        0, 0);

    $display("[TB] flush and start together in IDLE");
    start = 1'b1; flush = 1'b1; op = DIVU; a = 32'd9; b = 32'd3;
    #1;
    checkOutput("flush_start_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    #1;
    checkOutput("flush_start_busy", {63'd0, busy}, 64'd0);

    $display("[TB] random vectors");
    for (int i = 0; i < 24; i++) begin
      rOp = 2'($urandom_range(0, 3));
      rA  = $urandom;
      rB  = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) rB = 32'd0;
      if ($urandom_range(0, 7) == 0) rA = 32'h8000_0000;
      applyStimulus(rOp, rA, rB, (i % 3 == 0) ? int'($urandom_range(1, 31)) : 0, 0);
    end

    $display("[TB] reset mid-operation");
    op = MULT; a = 32'd123; b = 32'd456; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    #1;
    checkOutput("midrst_hi", {32'd0, hi}, 64'd0);
    checkOutput("midrst_lo", {32'd0, lo}, 64'd0);
    checkOutput("midrst_flags", {61'd0, done, busy, stall}, 64'd0);
    rst_n = 1'b1;
    doneSeen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      #1;
      if (done) doneSeen++;
    end
    checkOutput("midrst_no_done", 64'(doneSeen), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal: even, 8..64).
REQ-002 SHALL derive localparam CW = clog2(WIDTH+1), the iteration counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset: synchronous, active-low.
REQ-005 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-006 SHALL have port op  input  2  operation: MULT, MULTU, DIV, DIVU (package encodings).
REQ-007 SHALL have port a  input  WIDTH  multiplicand / dividend, captured on accept.
REQ-008 SHALL have port b  input  WIDTH  multiplier / divisor, captured on accept.
REQ-009 SHALL have port flush  input  1  abort any operation in progress (exception/interrupt).
REQ-010 SHALL have port hi  output  WIDTH  product upper half or remainder.
REQ-011 SHALL have port lo  output  WIDTH  product lower half or quotient.
REQ-012 SHALL have port done  output  1  one-cycle pulse: hi/lo hold a new result.
REQ-013 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-014 SHALL have port stall  output  1  pipeline hold request.

Function
REQ-015 SHALL implement states IDLE, CALC and DONE.
REQ-016 Transitions SHALL be: IDLE->CALC on start & ~flush; CALC->DONE when the counter reaches WIDTH; DONE->IDLE unconditionally; any state->IDLE on flush.
REQ-017 On accept, SHALL register op and the absolute values of a and b; absolute values apply only for signed ops, with the MSB treated as sign.
REQ-018 SHALL record the result sign on accept: quotient/product negative iff a and b signs differ (signed ops only); remainder takes the sign of a.
REQ-019 MULT/MULTU: CALC SHALL perform one shift-add step per cycle over a 2*WIDTH accumulator.
REQ-020 DIV/DIVU: CALC SHALL perform one restoring shift-subtract step per cycle.
REQ-021 CALC SHALL last exactly WIDTH cycles; done SHALL assert in the cycle WIDTH+1 after the accept edge (cycle 33 for WIDTH=32).
REQ-022 On the CALC->DONE edge, SHALL apply sign fix-up and load hi/lo; hi/lo SHALL then hold until the next CALC->DONE edge.
REQ-023 Divide by zero (b==0) SHALL give lo = all ones and hi = a (unmodified), with no exception and unchanged latency.
REQ-024 Signed overflow (a = most-negative, b = -1) SHALL give lo = most-negative and hi = 0.
REQ-025 stall SHALL = (state==IDLE & start & ~flush) | (state==CALC); it SHALL be low in DONE and low whenever flush is high.
REQ-026 start while busy SHALL be ignored, with no effect on state or operands.
REQ-027 flush in CALC or DONE SHALL suppress done, leave hi/lo at their previous values, and return to IDLE next cycle.
REQ-028 start in the cycle after a flush SHALL be accepted normally.
REQ-029 flush and start in the same IDLE cycle: flush SHALL win, and the operation SHALL not be accepted.
REQ-030 Back-to-back: start in the DONE cycle SHALL be ignored; the earliest re-accept is the following IDLE cycle.

Reset
REQ-031 On rst_n low at a clock edge: state = IDLE, counter = 0, hi = 0, lo = 0, done = 0, busy = 0, stall = 0.
REQ-032 Reset mid-operation SHALL discard the operation; no done pulse SHALL follow.
REQ-033 All registers SHALL be synchronously reset; no asynchronous reset paths SHALL exist.

Structure
REQ-034 Shared package muldiv_pkg SHALL hold the op encodings (MULT=2'b00, MULTU=2'b01, DIV=2'b10, DIVU=2'b11) and the state enum.
REQ-035 A single sub-module md_signfix SHALL hold the parametrised abs/conditional-negate logic, instanced for operand and result paths.
REQ-036 The datapath SHALL share one WIDTH+1-bit adder/subtractor between multiply and divide.

Verification (WIDTH=32)
REQ-037 MULT a=0xFFFFFFFE, b=3 -> done at cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFFA; stall high cycles 0..32.
REQ-038 DIVU a=100, b=7 -> lo=14, hi=2. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-039 DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-040 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-041 Accept DIVU 100/7, flush at cycle 10 -> no done, busy low at cycle 11, hi/lo unchanged; then MULTU 6*7 -> lo=42, hi=0 after 33 cycles.
REQ-042 Start pulsed during CALC with different operands -> ignored, original result returned; rst_n low at cycle 5 -> all outputs 0, no done.
